board_run_controller: RTL and testbench

- Board-level run/step/reset sequencer for the MIPS core.
- Owns debouncing of three raw push-buttons from the constraints file and turns them into core control signals:
  - cpu_en: clock-enable to the core.
  - cpu_rst: synchronous reset pulse to the core.
- Internal sample-tick prescaler, so no derived slow clock is needed.
- Sits between the board pins and the processor top; the core runs on the same clk.

---
 rtl/board_run_controller.sv | 155 +++++++++++++++
 tb/tb_board_run_controller.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/board_run_controller.sv
// Board-level run/step/reset sequencer: debounces three raw buttons on a sample tick
// and drives the core clock-enable, core reset and status LEDs.
module board_run_controller #(
    parameter int CLK_HZ     = 100000000,
    parameter int SAMPLE_HZ  = 5000,
    parameter int DEPTH      = 16,
    parameter int RST_CYCLES = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_run,
    input  logic btn_step,
    input  logic btn_rst,
    output logic cpu_en,
    output logic cpu_rst,
    output logic running,
    output logic halted
);

    localparam int DIV      = CLK_HZ / SAMPLE_HZ;
    localparam int PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW       = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int NB       = 3;
    localparam int BTN_RUN  = 0;
    localparam int BTN_STEP = 1;
    localparam int BTN_RST  = 2;

    typedef enum logic [1:0] {
        ST_HALT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STEP     = 2'd2,
        ST_CORE_RST = 2'd3
    } state_t;

    logic [PW-1:0] presc_reg;
    logic          tick;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] press;
    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;

    assign tick    = (presc_reg == PW'(DIV - 1));
    assign btn_raw = {btn_rst, btn_step, btn_run};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_reg <= '0;
        end else if (tick) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_reg + 1'b1;
        end
    end

    // Per-button synchronizer, tick-sampled history with hysteresis, and rising-edge detect.
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_btn
            logic             sync1_reg;
            logic             sync2_reg;
            logic [DEPTH-1:0] hist_reg;
            logic             level_reg;
            logic             level_dly_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync1_reg     <= 1'b0;
                    sync2_reg     <= 1'b0;
                    hist_reg      <= '0;
                    level_reg     <= 1'b0;
                    level_dly_reg <= 1'b0;
                end else begin
                    sync1_reg     <= btn_raw[gi];
                    sync2_reg     <= sync1_reg;
                    level_dly_reg <= level_reg;
                    if (tick) begin
                        hist_reg <= DEPTH'({hist_reg, sync2_reg});
                    end
                    if (&hist_reg) begin
                        level_reg <= 1'b1;
                    end else if (~|hist_reg) begin
                        level_reg <= 1'b0;
                    end
                end
            end

            assign press[gi] = level_reg & ~level_dly_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_HALT;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Reset press wins over everything; run wins over step.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (press[BTN_RST]) begin
            state_next = ST_CORE_RST;
            cnt_next   = CW'(RST_CYCLES - 1);
        end else begin
            case (state_reg)
                ST_HALT: begin
                    if (press[BTN_RUN]) begin
                        state_next = ST_RUN;
                    end else if (press[BTN_STEP]) begin
                        state_next = ST_STEP;
                    end
                end
                ST_RUN: begin
                    if (press[BTN_RUN]) begin
                        state_next = ST_HALT;
                    end
                end
                ST_STEP: begin
                    state_next = ST_HALT;
                end
                ST_CORE_RST: begin
                    if (cnt_reg == '0) begin
                        state_next = ST_HALT;
                    end else begin
                        cnt_next = cnt_reg - 1'b1;
                    end
                end
                default: begin
                    state_next = ST_HALT;
                end
            endcase
        end
    end

    always_comb begin
        cpu_en  = 1'b0;
        cpu_rst = 1'b0;
        running = 1'b0;
        halted  = 1'b0;
        case (state_reg)
            ST_HALT:     halted  = 1'b1;
            ST_RUN: begin
                cpu_en  = 1'b1;
                running = 1'b1;
            end
            ST_STEP:     cpu_en  = 1'b1;
            ST_CORE_RST: cpu_rst = 1'b1;
            default:     halted  = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_board_run_controller.sv
// Scoreboarded bench for board_run_controller: expected output segments are queued with
// the stimulus and compared by a monitor whenever the output vector changes.
module tb_board_run_controller;

    localparam logic [3:0] O_HALT = 4'b0001;
    localparam logic [3:0] O_RUN  = 4'b1010;
    localparam logic [3:0] O_STEP = 4'b1000;
    localparam logic [3:0] O_CRST = 4'b0100;

    logic clk = 1'b0;
    logic rst_n;
    logic btn_run, btn_step, btn_rst;
    logic cpu_en, cpu_rst, running, halted;

    typedef struct {
        logic [3:0] outs;
        int         len;
    } seg_t;

    seg_t       exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [3:0] cur_outs = O_HALT;
    int         cur_len = 0;
    int         cur_exp_len = 0;
    bit         mon_en = 1'b0;

    board_run_controller #(
        .CLK_HZ    (1000),
        .SAMPLE_HZ (250),
        .DEPTH     (4),
        .RST_CYCLES(3)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_run (btn_run),
        .btn_step(btn_step),
        .btn_rst (btn_rst),
        .cpu_en  (cpu_en),
        .cpu_rst (cpu_rst),
        .running (running),
        .halted  (halted)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] o, input int len);
        seg_t s;
        s.outs = o;
        s.len  = len;
        exp_q.push_back(s);
    endtask

    task automatic drain(input string tag);
        check_val(tag, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Monitor: each change of {cpu_en,cpu_rst,running,halted} is one transaction.
    always @(negedge clk) begin
        logic [3:0] o;
        seg_t       s;
        if (mon_en) begin
            o = {cpu_en, cpu_rst, running, halted};
            if (o !== cur_outs) begin
                $display("[%0t] outs %b -> %b after %0d clk", $time, cur_outs, o, cur_len);
                if (cur_exp_len != 0) check_val("seg_len", cur_len, cur_exp_len);
                if (exp_q.size() == 0) begin
                    check_val("unexpected_change", o, cur_outs);
                    cur_exp_len = 0;
                end else begin
                    s = exp_q.pop_front();
                    check_val("out_vec", o, s.outs);
                    cur_exp_len = s.len;
                end
                cur_outs = o;
                cur_len  = 1;
            end else begin
                cur_len++;
            end
        end
    end

    initial begin
        int first_tick;
        int n_ticks;
        int n;
        bit seen;

        rst_n = 1'b1; btn_run = 1'b0; btn_step = 1'b0; btn_rst = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_val("reset_outs", {cpu_en, cpu_rst, running, halted}, O_HALT);
        mon_en = 1'b1;
        cyc(3);
        rst_n = 1'b1;

        // 1: idle, prescaler period
        first_tick = 0;
        n_ticks = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (dut.tick) begin
                if (n_ticks == 0) first_tick = i;
                n_ticks++;
            end
        end
        check_val("first_tick", first_tick, 4);
        check_val("tick_count", n_ticks, 25);
        check_val("idle_outs", {cpu_en, cpu_rst, running, halted}, O_HALT);
        cyc(1);

        // 2: held step button gives one step
        push(O_STEP, 1); push(O_HALT, 0);
        btn_step = 1'b1; cyc(40);
        btn_step = 1'b0; cyc(40);
        drain("step_drain");

        // 3: bounce rejection, then clean run press and clean halt press
        for (int i = 0; i < 10; i++) begin
            btn_run = (i % 2 == 0); cyc(6);
        end
        btn_run = 1'b0; cyc(30);
        check_val("bounce_halt", {cpu_en, cpu_rst, running, halted}, O_HALT);
        drain("bounce_drain");
        push(O_RUN, 0);
        btn_run = 1'b1; cyc(30);
        btn_run = 1'b0; cyc(30);
        push(O_HALT, 0);
        btn_run = 1'b1; cyc(30);
        btn_run = 1'b0; cyc(30);
        drain("run_halt_drain");

        // 4: core reset from RUN; a coincident step press is ignored
        push(O_RUN, 0);
        btn_run = 1'b1; cyc(30);
        btn_run = 1'b0; cyc(30);
        push(O_CRST, 3); push(O_HALT, 0);
        btn_rst = 1'b1; btn_step = 1'b1; cyc(30);
        btn_rst = 1'b0; btn_step = 1'b0; cyc(30);
        drain("core_rst_drain");

        // 5: simultaneous presses
        push(O_RUN, 0);
        btn_run = 1'b1; btn_step = 1'b1; cyc(30);
        btn_run = 1'b0; btn_step = 1'b0; cyc(30);
        push(O_HALT, 0);
        btn_run = 1'b1; cyc(30);
        btn_run = 1'b0; cyc(30);
        push(O_CRST, 3); push(O_HALT, 0);
        btn_rst = 1'b1; btn_run = 1'b1; cyc(30);
        btn_rst = 1'b0; btn_run = 1'b0; cyc(30);
        drain("simul_drain");

        // 6a: async reset while running
        push(O_RUN, 0);
        btn_run = 1'b1; cyc(30);
        btn_run = 1'b0; cyc(30);
        push(O_HALT, 0);
        #1 rst_n = 1'b0;
        #1;
        check_val("arst_run_outs", {cpu_en, cpu_rst, running, halted}, O_HALT);
        cyc(2);
        rst_n = 1'b1; cyc(10);
        drain("arst_run_drain");

        // 6b: async reset in 2nd cycle of CORE_RST with btn_rst still held
        push(O_CRST, 0); push(O_HALT, 0);
        btn_rst = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (cpu_rst) seen = 1'b1;
        end
        check_val("crst_seen", seen, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_crst_outs", {cpu_en, cpu_rst, running, halted}, O_HALT);
        cyc(2);
        push(O_CRST, 3); push(O_HALT, 0);
        rst_n = 1'b1;
        n = 0;
        seen = 1'b0;
        for (int i = 1; i <= 60 && !seen; i++) begin
            @(negedge clk);
            if (cpu_rst) begin
                seen = 1'b1;
                n = i;
            end
        end
        check_val("held_after_arst_seen", seen, 1);
        check_val("held_needs_depth_ticks", (n >= 16 && n <= 24), 1);
        cyc(1);
        btn_rst = 1'b0; cyc(40);
        drain("arst_crst_drain");
        check_val("final_outs", {cpu_en, cpu_rst, running, halted}, O_HALT);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
